alu_issue_stage: RTL
====================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width of operands and forwarded values.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state on rising edge.
- resetn  in  1  synchronous, active-low reset.
- ds_valid  in  1  decode bundle valid.
- es_allowin  out  1  stage can accept a bundle this cycle.
- ds_op  in  3  opcode: 000 ADD, 001 SUB, 010 ADDI, 011 SLT; others are NOP.
- ds_rs, ds_rt  in  5 each  source register numbers.
- ds_rs_val, ds_rt_val  in  WIDTH each  register-file read values.
- ds_imm  in  16  immediate.
- ds_dest  in  5  destination register.
- flush  in  1  kill the bundle in this stage.
- ms_allowin  in  1  downstream can accept.
- fwd_ms_valid, fwd_ms_dest, fwd_ms_val  in  1/5/WIDTH  memory-stage bypass.
- fwd_ws_valid, fwd_ws_dest, fwd_ws_val  in  1/5/WIDTH  writeback-stage bypass.
- es_valid  out  1  stage holds a live bundle.
- es_to_ms_valid  out  1  bundle offered downstream.
- A, B  out  WIDTH each  adder operands.
- Cin  out  1  adder carry-in.
- es_op  out  3  latched opcode.
- es_dest  out  5  latched destination.

Function
REQ-003 SHALL use es_ready_go = 1, es_allowin = !es_valid || ms_allowin, and es_to_ms_valid = es_valid.
REQ-004 SHALL latch ds_op, ds_rs, ds_rt, ds_rs_val, ds_rt_val, ds_imm and ds_dest when ds_valid && es_allowin.
REQ-005 SHALL update es_valid by priority:
- flush gives 0;
- else es_allowin gives ds_valid;
- else es_valid holds.
REQ-006 SHALL give flush priority over a simultaneous load; the bundle fields may still latch, but es_valid = 0 next cycle.
REQ-007 SHALL hold all latched fields unchanged while es_valid && !ms_allowin.
REQ-008 SHALL drive operands per opcode:
- ADD: A = rs, B = rt, Cin = 0.
- SUB and SLT: A = rs, B = ~rt, Cin = 1.
- ADDI: A = rs, B = sign-extended imm (bit 15 replicated to WIDTH), Cin = 0.
- NOP: A = 0, B = 0, Cin = 0, es_dest = 0.
REQ-009 SHALL derive A, B and Cin combinationally from the latched state and the bypass inputs, with zero added latency.
REQ-010 SHALL force A, B and Cin to 0 whenever es_valid = 0.
REQ-011 SHALL give a source hit only when fwd_x_valid = 1, fwd_x_dest == the source number, and the source number != 0.
REQ-012 SHALL let a memory-stage hit override a writeback-stage hit, and a writeback-stage hit override the latched value.
REQ-013 SHALL write the selected bypass value into the latched operand register on every cycle with a hit while es_valid, so the value persists after the producer retires.
REQ-014 SHALL never forward for register 0; the latched value is used.

Reset
REQ-015 SHALL, when resetn = 0 at a rising edge, clear es_valid, es_op, es_dest and the operand and immediate registers to 0.
REQ-016 SHALL, during reset, drive es_allowin = 1, es_to_ms_valid = 0 and A = B = Cin = 0.
REQ-017 SHALL let reset override load and flush in the same cycle, and discard any bundle in flight.

Configuration
REQ-018 SHALL implement macro ALU_ISSUE_FORWARD_EN:
- Defined: REQ-011 to REQ-014 active.
- Undefined: bypass inputs ignored, operands come only from latched values, no capture logic.
- Interlock is then decode's responsibility.

Verification
REQ-019 Load ADD with rs_val = 5, rt_val = 7 -> next cycle es_valid = 1, A = 5, B = 7, Cin = 0.
REQ-020 Load SUB with rs_val = 9, rt_val = 3 -> B = 0xFFFFFFFC, Cin = 1; ADDI with imm = 0x8000 -> B = 0xFFFF8000.
REQ-021 Hold ms_allowin = 0 for 3 cycles with ds_valid = 1 -> es_allowin = 0, and fields and outputs stable.
REQ-022 Assert flush and load in the same cycle -> es_valid = 0 next cycle; also check reset asserted mid-stall clears state.
REQ-023 ALU_ISSUE_FORWARD_EN defined, rs = 4:
- Both ms and ws hit (ms_val = 0x11, ws_val = 0x22) -> A = 0x11.
- Deassert fwd_ms_valid while stalled -> A stays 0x11.
- rs = 0 with a hit -> latched value used.
REQ-024 ALU_ISSUE_FORWARD_EN undefined, same stimulus -> A = latched rs_val.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue stage: latches a decode bundle and presents adder operands A/B/Cin.
// Optional operand bypass from the memory/writeback stages: define ALU_ISSUE_FORWARD_EN.
module alu_issue_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ds_valid,
  output logic             es_allowin,
  input  logic [2:0]       ds_op,
  input  logic [4:0]       ds_rs,
  input  logic [4:0]       ds_rt,
  input  logic [WIDTH-1:0] ds_rs_val,
  input  logic [WIDTH-1:0] ds_rt_val,
  input  logic [15:0]      ds_imm,
  input  logic [4:0]       ds_dest,
  input  logic             flush,
  input  logic             ms_allowin,
  input  logic             fwd_ms_valid,
  input  logic [4:0]       fwd_ms_dest,
  input  logic [WIDTH-1:0] fwd_ms_val,
  input  logic             fwd_ws_valid,
  input  logic [4:0]       fwd_ws_dest,
  input  logic [WIDTH-1:0] fwd_ws_val,
  output logic             es_valid,
  output logic             es_to_ms_valid,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Cin,
  output logic [2:0]       es_op,
  output logic [4:0]       es_dest
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam int unsigned EXT_W  = WIDTH - 16;

  logic [WIDTH-1:0] rs_val_q;
  logic [WIDTH-1:0] rt_val_q;
  logic [15:0]      imm_q;
  logic [WIDTH-1:0] rs_cur;
  logic [WIDTH-1:0] rt_cur;
  logic             load;
  logic             ds_is_nop;

  // Handshake; reset is folded in so outputs are defined before the first edge.
  assign es_allowin     = !resetn || !es_valid || ms_allowin;
  assign es_to_ms_valid = resetn && es_valid;
  assign load           = ds_valid && es_allowin;
  assign ds_is_nop      = (ds_op != OP_ADD) && (ds_op != OP_SUB) &&
                          (ds_op != OP_ADDI) && (ds_op != OP_SLT);

`ifdef ALU_ISSUE_FORWARD_EN
  logic [4:0] es_rs_q;
  logic [4:0] es_rt_q;
  logic       rs_ms_hit, rs_ws_hit, rt_ms_hit, rt_ws_hit;
  logic       rs_hit, rt_hit;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      es_rs_q <= 5'd0;
      es_rt_q <= 5'd0;
    end else if (load) begin
      es_rs_q <= ds_rs;
      es_rt_q <= ds_rt;
    end
  end

  // Register 0 never matches a producer.
  assign rs_ms_hit = fwd_ms_valid && (fwd_ms_dest == es_rs_q) && (es_rs_q != 5'd0);
  assign rs_ws_hit = fwd_ws_valid && (fwd_ws_dest == es_rs_q) && (es_rs_q != 5'd0);
  assign rt_ms_hit = fwd_ms_valid && (fwd_ms_dest == es_rt_q) && (es_rt_q != 5'd0);
  assign rt_ws_hit = fwd_ws_valid && (fwd_ws_dest == es_rt_q) && (es_rt_q != 5'd0);
  assign rs_hit    = rs_ms_hit || rs_ws_hit;
  assign rt_hit    = rt_ms_hit || rt_ws_hit;
  assign rs_cur    = rs_ms_hit ? fwd_ms_val : (rs_ws_hit ? fwd_ws_val : rs_val_q);
  assign rt_cur    = rt_ms_hit ? fwd_ms_val : (rt_ws_hit ? fwd_ws_val : rt_val_q);
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_ms_valid, fwd_ms_dest, fwd_ms_val,
                        fwd_ws_valid, fwd_ws_dest, fwd_ws_val, ds_rs, ds_rt};
  assign rs_cur     = rs_val_q;
  assign rt_cur     = rt_val_q;
`endif

  // Bundle registers; a bypassed value is captured so it outlives its producer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      es_valid <= 1'b0;
      es_op    <= 3'd0;
      es_dest  <= 5'd0;
      rs_val_q <= '0;
      rt_val_q <= '0;
      imm_q    <= 16'd0;
    end else begin
      if (flush)           es_valid <= 1'b0;
      else if (es_allowin) es_valid <= ds_valid;

      if (load) begin
        es_op    <= ds_op;
        es_dest  <= ds_is_nop ? 5'd0 : ds_dest;
        rs_val_q <= ds_rs_val;
        rt_val_q <= ds_rt_val;
        imm_q    <= ds_imm;
      end
`ifdef ALU_ISSUE_FORWARD_EN
      else if (es_valid) begin
        if (rs_hit) rs_val_q <= rs_cur;
        if (rt_hit) rt_val_q <= rt_cur;
      end
`endif
    end
  end

  // Adder operand selection; idle or reset stage presents zeros.
  always_comb begin
    A   = '0;
    B   = '0;
    Cin = 1'b0;
    if (resetn && es_valid) begin
      case (es_op)
        OP_ADD: begin
          A = rs_cur;
          B = rt_cur;
        end
        OP_SUB, OP_SLT: begin
          A   = rs_cur;
          B   = ~rt_cur;
          Cin = 1'b1;
        end
        OP_ADDI: begin
          A = rs_cur;
          B = {{EXT_W{imm_q[15]}}, imm_q};
        end
        default: begin
          A   = '0;
          B   = '0;
          Cin = 1'b0;
        end
      endcase
    end
  end

endmodule
